// File: rtl/sram_like_bridge.sv
// Pipeline SRAM port to SRAM-like req/addr_ok/data_ok bus bridge.
// Optional flush/DROP path enabled by defining BRIDGE_FLUSH_EN.
module sram_like_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit RD_ONLY = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
`ifdef BRIDGE_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                sram_en,
    input  logic                sram_wr,
    input  logic [DATA_W/8-1:0] sram_be,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W-1:0]   sram_rdata,
    output logic                sram_stall,
    input  logic                longest_stall,
    output logic                be_err,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [1:0] FULL_SIZE = (DATA_W == 64) ? 2'd3 : 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
`ifdef BRIDGE_FLUSH_EN
        , S_DROP
`endif
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             cap_req;
    logic             cap_rd;
    logic             be_legal;
    logic [1:0]       dec_size;
    logic [OFF_W-1:0] dec_off;

    // Naturally aligned byte/half/word/dword patterns; anything else
    // falls back to a full-width aligned access.
    always_comb begin
        be_legal = 1'b0;
        dec_size = FULL_SIZE;
        dec_off  = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (sram_be == (BE_W'(1) << i)) begin
                be_legal = 1'b1;
                dec_size = 2'd0;
                dec_off  = OFF_W'(i);
            end
        end
        for (int i = 0; i < BE_W / 2; i++) begin
            if (sram_be == (BE_W'(3) << (2 * i))) begin
                be_legal = 1'b1;
                dec_size = 2'd1;
                dec_off  = OFF_W'(2 * i);
            end
        end
        for (int i = 0; i < BE_W / 4; i++) begin
            if (sram_be == (BE_W'(15) << (4 * i))) begin
                be_legal = 1'b1;
                dec_size = 2'd2;
                dec_off  = OFF_W'(4 * i);
            end
        end
        if (sram_be == {BE_W{1'b1}}) begin
            be_legal = 1'b1;
            dec_size = FULL_SIZE;
            dec_off  = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_req   = 1'b0;
        cap_rd    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (sram_en) begin
                    cap_req   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_addr_ok && bus_data_ok) begin
                    cap_rd    = 1'b1;
                    state_nxt = S_DONE;
                end else if (bus_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    cap_rd    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!longest_stall) begin
                    state_nxt = S_IDLE;
                end
            end
`ifdef BRIDGE_FLUSH_EN
            S_DROP: begin
                if (bus_data_ok) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
`ifdef BRIDGE_FLUSH_EN
        // A transaction already accepted by the bus must drain its data
        if (flush) begin
            cap_req = 1'b0;
            cap_rd  = 1'b0;
            unique case (state)
                S_REQ: begin
                    if (bus_addr_ok && !bus_data_ok) begin
                        state_nxt = S_DROP;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_WAIT: begin
                    state_nxt = bus_data_ok ? S_IDLE : S_DROP;
                end
                S_DROP: begin
                    state_nxt = bus_data_ok ? S_IDLE : S_DROP;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_wr     <= 1'b0;
            bus_size   <= 2'd0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            sram_rdata <= '0;
        end else begin
            if (cap_req) begin
                bus_wr    <= sram_wr & ~RD_ONLY;
                bus_size  <= dec_size;
                bus_addr  <= {sram_addr[ADDR_W-1:OFF_W], dec_off};
                bus_wdata <= RD_ONLY ? '0 : sram_wdata;
            end
            if (cap_rd) begin
                sram_rdata <= bus_rdata;
            end
        end
    end

    assign bus_req    = (state == S_REQ);
    assign sram_stall = ~rst & sram_en & (state != S_DONE);
    assign be_err     = ~rst & sram_en & ~be_legal;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: fetch, store, hold, decode, flush, reset.
// Three instances share control inputs: data32, fetch32 (RD_ONLY) and data64.
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr;
    logic [3:0]  be;
    logic [7:0]  be64;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ls;
    logic        aok;
    logic        dok;
    logic        flush;

    logic [31:0] a_rdata, a_addr, a_wdata;
    logic        a_stall, a_err, a_req, a_wr;
    logic [1:0]  a_size;
    logic [31:0] f_rdata, f_addr, f_wdata;
    logic        f_stall, f_err, f_req, f_wr;
    logic [1:0]  f_size;
    logic [63:0] w_rdata, w_wdata;
    logic [31:0] w_addr;
    logic        w_stall, w_err, w_req, w_wr;
    logic [1:0]  w_size;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .RD_ONLY(1'b0)) u_data (
        .clk(clk), .rst(rst),
`ifdef BRIDGE_FLUSH_EN
        .flush(flush),
`endif
        .sram_en(en), .sram_wr(wr), .sram_be(be), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(a_rdata), .sram_stall(a_stall),
        .longest_stall(ls), .be_err(a_err), .bus_req(a_req), .bus_wr(a_wr),
        .bus_size(a_size), .bus_addr(a_addr), .bus_wdata(a_wdata),
        .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata(rdata)
    );

    sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .RD_ONLY(1'b1)) u_fetch (
        .clk(clk), .rst(rst),
`ifdef BRIDGE_FLUSH_EN
        .flush(flush),
`endif
        .sram_en(en), .sram_wr(wr), .sram_be(be), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(f_rdata), .sram_stall(f_stall),
        .longest_stall(ls), .be_err(f_err), .bus_req(f_req), .bus_wr(f_wr),
        .bus_size(f_size), .bus_addr(f_addr), .bus_wdata(f_wdata),
        .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata(rdata)
    );

    sram_like_bridge #(.ADDR_W(32), .DATA_W(64), .RD_ONLY(1'b0)) u_wide (
        .clk(clk), .rst(rst),
`ifdef BRIDGE_FLUSH_EN
        .flush(flush),
`endif
        .sram_en(en), .sram_wr(wr), .sram_be(be64), .sram_addr(addr),
        .sram_wdata({32'h0, wdata}), .sram_rdata(w_rdata),
        .sram_stall(w_stall), .longest_stall(ls), .be_err(w_err),
        .bus_req(w_req), .bus_wr(w_wr), .bus_size(w_size),
        .bus_addr(w_addr), .bus_wdata(w_wdata),
        .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata({32'h0, rdata})
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  v_be   [5] = '{4'b1000, 4'b1100, 4'b0101, 4'b0001, 4'b0110};
    logic [7:0]  v_be64 [5] = '{8'h80, 8'h30, 8'hFF, 8'hF0, 8'h3C};
    logic [1:0]  v_sz   [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [31:0] v_ad   [5] = '{32'h80000013, 32'h80000012, 32'h80000010,
                                32'h80000010, 32'h80000010};
    logic        v_er   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  v_sz64 [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3};
    logic [31:0] v_ad64 [5] = '{32'h80000017, 32'h80000014, 32'h80000010,
                                32'h80000014, 32'h80000010};
    logic        v_er64 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; en = 1'b1; wr = 1'b0; be = 4'b0101; be64 = 8'h00;
        addr = 32'h0; wdata = 32'h0; rdata = 32'h0; ls = 1'b0;
        aok = 1'b0; dok = 1'b0; flush = 1'b0;
        step;
        step;
        chk("rst_req", a_req, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_be_err", a_err, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_size", a_size, 0);
        rst = 1'b0; en = 1'b0;
        step;

        // fetch: addr_ok at c1, data_ok at c3
        en = 1'b1; wr = 1'b1; be = 4'hF; addr = 32'hBFC00000;
        wdata = 32'h12345678;
        #1;
        chk("fetch_c0_stall", f_stall, 1);
        chk("fetch_c0_req", f_req, 0);
        step;
        aok = 1'b1;
        #1;
        chk("fetch_c1_req", f_req, 1);
        chk("fetch_c1_wr", f_wr, 0);
        chk("fetch_c1_size", f_size, 2);
        chk("fetch_c1_addr", f_addr, 32'hBFC00000);
        chk("fetch_c1_stall", f_stall, 1);
        chk("data_c1_wr", a_wr, 1);
        step;
        aok = 1'b0;
        #1;
        chk("fetch_c2_req", f_req, 0);
        chk("fetch_c2_stall", f_stall, 1);
        step;
        dok = 1'b1; rdata = 32'h3C010001;
        #1;
        chk("fetch_c3_req", f_req, 0);
        chk("fetch_c3_stall", f_stall, 1);
        step;
        dok = 1'b0; rdata = 32'h0;
        #1;
        chk("fetch_c4_stall", f_stall, 0);
        chk("fetch_c4_rdata", f_rdata, 32'h3C010001);
        en = 1'b0;
        step;

        // byte store, addr_ok withheld 3 cycles, core inputs disturbed
        en = 1'b1; wr = 1'b1; be = 4'b0100; addr = 32'h80001000;
        wdata = 32'h00AB0000;
        #1;
        chk("sb_c0_be_err", a_err, 0);
        step;
        addr = 32'h12340000; be = 4'hF; wdata = 32'hFFFFFFFF; wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("sb_hold%0d_req", k), a_req, 1);
            chk($sformatf("sb_hold%0d_addr", k), a_addr, 32'h80001002);
            chk($sformatf("sb_hold%0d_size", k), a_size, 0);
            chk($sformatf("sb_hold%0d_wr", k), a_wr, 1);
            chk($sformatf("sb_hold%0d_wdata", k), a_wdata, 32'h00AB0000);
            step;
        end
        aok = 1'b1; dok = 1'b1;
        #1;
        chk("sb_c4_req", a_req, 1);
        step;
        aok = 1'b0; dok = 1'b0;
        #1;
        chk("sb_c5_stall", a_stall, 0);
        en = 1'b0;
        step;

        // hold in DONE under longest_stall
        en = 1'b1; wr = 1'b0; be = 4'hF; addr = 32'h80002000;
        step;
        aok = 1'b1;
        step;
        aok = 1'b0; dok = 1'b1; rdata = 32'h11223344;
        step;
        dok = 1'b0; ls = 1'b1; rdata = 32'h55555555;
        for (int c = 3; c < 6; c++) begin
            #1;
            chk($sformatf("hold_c%0d_stall", c), a_stall, 0);
            chk($sformatf("hold_c%0d_rdata", c), a_rdata, 32'h11223344);
            chk($sformatf("hold_c%0d_req", c), a_req, 0);
            step;
        end
        ls = 1'b0;
        #1;
        chk("hold_c6_stall", a_stall, 0);
        chk("hold_c6_rdata", a_rdata, 32'h11223344);
        step;
        #1;
        chk("hold_c7_stall", a_stall, 1);
        chk("hold_c7_req", a_req, 0);
        step;
        #1;
        chk("hold_c8_req", a_req, 1);
        aok = 1'b1; dok = 1'b1;
        step;
        aok = 1'b0; dok = 1'b0; en = 1'b0;
        step;

        // byte-select decode, 32 and 64 bit
        rdata = 32'h600D600D;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; wr = 1'b0; be = v_be[i]; be64 = v_be64[i];
            addr = 32'h80000010;
            #1;
            chk($sformatf("dec%0d_err32", i), a_err, v_er[i]);
            chk($sformatf("dec%0d_err64", i), w_err, v_er64[i]);
            step;
            aok = 1'b1; dok = 1'b1;
            #1;
            chk($sformatf("dec%0d_size32", i), a_size, v_sz[i]);
            chk($sformatf("dec%0d_addr32", i), a_addr, v_ad[i]);
            chk($sformatf("dec%0d_size64", i), w_size, v_sz64[i]);
            chk($sformatf("dec%0d_addr64", i), w_addr, v_ad64[i]);
            step;
            aok = 1'b0; dok = 1'b0; en = 1'b0;
            step;
        end

`ifdef BRIDGE_FLUSH_EN
        // flush in WAIT, late data must be dropped
        en = 1'b1; be = 4'hF; be64 = 8'hFF; addr = 32'h80004000;
        step;
        aok = 1'b1;
        step;
        aok = 1'b0; flush = 1'b1;
        step;
        flush = 1'b0; en = 1'b0; dok = 1'b1; rdata = 32'h0000DEAD;
        #1;
        chk("flush_drop_stall", a_stall, 0);
        step;
        dok = 1'b0; en = 1'b1;
        #1;
        chk("flush_rdata_kept", a_rdata, 32'h600D600D);
        chk("flush_idle_req", a_req, 0);
        chk("flush_idle_stall", a_stall, 1);
        step;
        #1;
        chk("flush_new_req", a_req, 1);
        aok = 1'b1; dok = 1'b1;
        step;
        aok = 1'b0; dok = 1'b0; en = 1'b0;
        step;
`endif

        // reset while waiting for data
        en = 1'b1; wr = 1'b1; be = 4'hF; be64 = 8'hFF;
        addr = 32'h80005000; wdata = 32'h0000CAFE;
        step;
        aok = 1'b1;
        step;
        aok = 1'b0; rst = 1'b1;
        step;
        rst = 1'b0; en = 1'b0; dok = 1'b1; rdata = 32'h00000BAD;
        #1;
        chk("rstw_req", a_req, 0);
        chk("rstw_wr", a_wr, 0);
        chk("rstw_addr", a_addr, 0);
        chk("rstw_wdata", a_wdata, 0);
        chk("rstw_rdata", a_rdata, 0);
        chk("rstw_stall", a_stall, 0);
        step;
        dok = 1'b0;
        #1;
        chk("rstw_stale_rdata", a_rdata, 0);
        chk("rstw_stale_req", a_req, 0);
        en = 1'b1;
        #1;
        chk("rstw_idle_stall", a_stall, 1);
        en = 1'b0;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Parametrised converter from a pipeline-side SRAM port (enable, byte-select, write flag, stall) to an SRAM-like split-handshake bus (req/addr_ok/data_ok). It is the successor to the separate fixed-width instruction and data bridges and serves both channels through parameters:

- a read-only mode for fetch,
- configurable data width,
- byte-select-driven size and address derivation,
- an optional flush path for exception cancellation.

One instance sits between the MIPS core and each SRAM-like master port of the AXI interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64 only
- RD_ONLY, 0, 1 = fetch channel: bus_wr tied 0, sram_wr and sram_wdata ignored

- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- sram_en  in  1  access request from pipeline; held while stalled
- sram_wr  in  1  1 = store
- sram_be  in  DATA_W/8  byte selects, valid for loads and stores
- sram_addr  in  ADDR_W  word-aligned address from core
- sram_wdata  in  DATA_W  store data
- sram_rdata  out  DATA_W  load/fetch data, valid in DONE
- sram_stall  out  1  stall request to hazard unit
- longest_stall  in  1  global pipeline stall; result is held while high
- be_err  out  1  illegal byte-select pattern (combinational)
- bus_req, bus_wr  out  1 each
- bus_size  out  2
- bus_addr  out  ADDR_W
- bus_wdata  out  DATA_W
- bus_addr_ok, bus_data_ok  in  1 each
- bus_rdata  in  DATA_W
- flush  in  1  present only with BRIDGE_FLUSH_EN

## Operation
States: IDLE, REQ, WAIT, DONE; DROP exists only with the macro.

- IDLE: sram_en=1 → capture the request and go to REQ.
  - Captured fields: bus_addr, bus_size, bus_wr (sram_wr & ~RD_ONLY) and bus_wdata.
- REQ: bus_req=1.
  - bus_addr_ok & bus_data_ok → DONE.
  - bus_addr_ok only → WAIT.
  - Otherwise stay; request fields stay stable.
- WAIT: bus_req=0. bus_data_ok → DONE, capturing bus_rdata (don't-care for stores).
- DONE: sram_rdata = captured data.
  - longest_stall=0 → IDLE.
  - longest_stall=1 → stay and keep holding the data.
- sram_stall = sram_en & (state≠DONE); it is 0 during rst.
- Size/address derivation, DATA_W=32:
  - be 0001/0010/0100/1000 → size 0, addr[1:0] = 0/1/2/3.
  - be 0011/1100 → size 1, addr[1:0] = 0/2.
  - be 1111 → size 2, addr[1:0] = 0.
- Size/address derivation, DATA_W=64: same rules over addr[2:0], plus be 0xFF → size 3.
- Any other be pattern:
  - be_err=1 while sram_en is high.
  - The request is still issued as a full-width aligned access; the core raises the exception.
- A bus_data_ok that arrives in IDLE or DONE is ignored. Bus protocol guarantees this does not happen.

## Timing
- Reset: state IDLE; outputs all 0 (bus_req, bus_wr, bus_size, bus_addr, bus_wdata, sram_rdata, sram_stall, be_err).
  - Reset mid-transaction abandons the transaction. The bus side is reset by the same rst.
- Minimum latency: sram_en rises at cycle 0 → bus_req at cycle 1.
  - With addr_ok and data_ok both at cycle 1: DONE at cycle 2, sram_stall=0 at cycle 2.
- The bridge has one outstanding transaction at most; a new request issues no earlier than the cycle after leaving DONE.
- bus_req is registered. It is never asserted in the same cycle that sram_en first rises.

## Configuration
BRIDGE_FLUSH_EN:
- Defined: the flush port and the DROP state exist. flush has priority over all other transitions.
  - IDLE: the sram_en in that cycle is ignored.
  - REQ without addr_ok: request withdrawn, → IDLE.
  - REQ with addr_ok, no data_ok: → DROP.
  - REQ with addr_ok and data_ok: → IDLE.
  - WAIT: → DROP, or → IDLE if bus_data_ok is in the same cycle.
  - DONE: → IDLE.
  - DROP: bus_req=0, sram_stall = sram_en. bus_data_ok → IDLE; the data is discarded and sram_rdata is unchanged.
- Undefined: no flush port and no DROP state. Every accepted transaction runs to DONE.

## Test plan
- Fetch, RD_ONLY=1: sram_en=1, addr 0xBFC00000, be 1111, addr_ok at cycle 1, data_ok at cycle 3 with 0x3C010001.
  - Required: bus_req high only in cycle 1, bus_wr=0, size 2.
  - sram_stall high in cycles 0–3; sram_rdata=0x3C010001 from cycle 4.
- Byte store: be 0100, addr 0x80001000, wdata 0x00AB0000.
  - Required: bus_addr 0x80001002, size 0, bus_wr=1.
  - bus_addr_ok held low for 3 cycles: bus_req and all request fields held stable throughout.
- Hold under longest_stall: data_ok at cycle 2 with longest_stall=1 until cycle 6.
  - Required: state DONE and sram_rdata constant through cycle 6; IDLE at cycle 7; no second bus_req before cycle 8.
- be=0101:
  - Required: be_err=1, access issued with size 2, addr[1:0]=0.
  - DATA_W=64 with be 0xFF: size 3.
- BRIDGE_FLUSH_EN, flush in WAIT: next data_ok (0xDEAD) must not change sram_rdata.
  - Required: state returns to IDLE. A new sram_en in the following cycle produces bus_req one cycle later.
- Reset asserted in WAIT: all outputs 0 the next cycle; a stale data_ok is ignored.
